// File: rtl/ps2_pad_poller.sv
// ps2_pad_poller: periodic PlayStation-2 pad poller (CPOL=1, LSB first).
// It runs one frame, checks the 0x5A header and publishes active-high
// buttons plus mode_id, with a one-cycle valid/err strobe.
// Optional macro PS2_ANALOG_EN: 9-byte frames, stick outputs, and an
// analog-mode config sequence (three frames) after reset and whenever the
// pad reports a mode other than 0x73.
//
// Handshake: valid and err are single-cycle strobes with no ready. They
// rise in the cycle CS returns high. The data outputs change in that same
// cycle and are held until the next valid frame.
module ps2_pad_poller #(
    parameter int CLK_DIV     = 150,
    parameter int GAP_CYCLES  = 600,
    parameter int POLL_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] buttons,
`ifdef PS2_ANALOG_EN
    output logic [7:0]  stick_rx,
    output logic [7:0]  stick_ry,
    output logic [7:0]  stick_lx,
    output logic [7:0]  stick_ly,
`endif
    output logic [7:0]  mode_id,
    output logic        valid,
    output logic        err,
    output logic [2:0]  dbg_state
);

`ifdef PS2_ANALOG_EN
    localparam int NB = 9;
`else
    localparam int NB = 5;
`endif
    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [3:0]  LAST_BYTE = 4'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT, S_GAP, S_CS_HOLD, S_UPDATE, S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;     // divider, restarts on every state entry
    logic                 ph_q, ph_d;       // 0 = SCK low half, 1 = SCK high half
    logic [2:0]           bit_q, bit_d;
    logic [3:0]           byte_q, byte_d;
    logic [7:0]           sr_q, sr_d;
    logic [NB-1:1][7:0]   rx_q, rx_d;       // response bytes 1..NB-1 of current frame
    logic [15:0]          buttons_q, buttons_d;
    logic [7:0]           mode_q, mode_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 spi_cs_q, spi_cs_d;
    logic                 spi_clk_q, spi_clk_d;
    logic                 spi_mosi_q, spi_mosi_d;
    logic [7:0]           cmd_cur;
`ifdef PS2_ANALOG_EN
    logic [1:0]           cfg_q, cfg_d;     // 0 = poll frame, 1..3 = config frame number
    logic [7:0]           rx_stick_q, rx_stick_d;
    logic [7:0]           ry_stick_q, ry_stick_d;
    logic [7:0]           lx_stick_q, lx_stick_d;
    logic [7:0]           ly_stick_q, ly_stick_d;

    // Command byte for a frame kind: poll, enter config, analog+lock, exit config.
    function automatic logic [7:0] cmd_byte(input logic [1:0] kind, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 4'd0) begin
            b = 8'h01;
        end else begin
            case (kind)
                2'd0: begin
                    if (idx == 4'd1) b = 8'h42;
                end
                2'd1: begin
                    if (idx == 4'd1) b = 8'h43;
                    else if (idx == 4'd3) b = 8'h01;
                end
                2'd2: begin
                    if (idx == 4'd1) b = 8'h44;
                    else if (idx == 4'd3) b = 8'h01;
                    else if (idx == 4'd4) b = 8'h03;
                end
                default: begin
                    if (idx == 4'd1) b = 8'h43;
                    else if (idx >= 4'd4) b = 8'h5A;
                end
            endcase
        end
        return b;
    endfunction
`else
    // Command byte of the digital poll frame: 01 42 00 00 00.
    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 4'd0) b = 8'h01;
        else if (idx == 4'd1) b = 8'h42;
        return b;
    endfunction
`endif

    // Next-state, counters, shift register, frame commit and pad pin decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sr_d      = sr_q;
        rx_d      = rx_q;
        buttons_d = buttons_q;
        mode_d    = mode_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_ANALOG_EN
        cfg_d      = cfg_q;
        rx_stick_d = rx_stick_q;
        ry_stick_d = ry_stick_q;
        lx_stick_d = lx_stick_q;
        ly_stick_d = ly_stick_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                if (en) begin
                    state_d = S_CS_SETUP;
                    byte_d  = 4'd0;
                    bit_d   = 3'd0;
                    ph_d    = 1'b0;
                end
            end
            S_CS_SETUP, S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = 32'd0;
                    ph_d    = 1'b0;
                    bit_d   = 3'd0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 32'd0;
                    if (!ph_q) begin
                        // SCK rises now: capture MISO, LSB arrives first.
                        ph_d = 1'b1;
                        sr_d = {spi_miso, sr_q[7:1]};
                    end else if (bit_q != 3'd7) begin
                        ph_d  = 1'b0;
                        bit_d = bit_q + 3'd1;
                    end else begin
                        for (int i = 1; i < NB; i++) begin
                            if (byte_q == 4'(i)) rx_d[i] = sr_q;
                        end
                        if (byte_q == LAST_BYTE) begin
                            state_d = S_CS_HOLD;
                        end else begin
                            state_d = S_GAP;
                            byte_d  = byte_q + 4'd1;
                        end
                    end
                end
            end
            S_CS_HOLD: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_UPDATE;
                    cnt_d   = 32'd0;
                    // Commit lands together with CS rising.
`ifdef PS2_ANALOG_EN
                    if (cfg_q != 2'd0) begin
                        cfg_d = (cfg_q == 2'd3) ? 2'd0 : cfg_q + 2'd1;
                    end else if (rx_q[2] == 8'h5A) begin
                        valid_d    = 1'b1;
                        mode_d     = rx_q[1];
                        buttons_d  = ~{rx_q[4], rx_q[3]};
                        rx_stick_d = rx_q[5];
                        ry_stick_d = rx_q[6];
                        lx_stick_d = rx_q[7];
                        ly_stick_d = rx_q[8];
                        if (rx_q[1] != 8'h73) cfg_d = 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    if (rx_q[2] == 8'h5A) begin
                        valid_d   = 1'b1;
                        mode_d    = rx_q[1];
                        buttons_d = ~{rx_q[4], rx_q[3]};
                    end else begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            S_UPDATE: begin
                state_d = S_WAIT;
                cnt_d   = 32'd0;
            end
            S_WAIT: begin
                if (cnt_q == POLL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

`ifdef PS2_ANALOG_EN
        cmd_cur = cmd_byte(cfg_q, byte_d);
`else
        cmd_cur = cmd_byte(byte_d);
`endif
        spi_cs_d   = !((state_d == S_CS_SETUP) || (state_d == S_SHIFT) ||
                       (state_d == S_GAP) || (state_d == S_CS_HOLD));
        spi_clk_d  = (state_d == S_SHIFT) ? ph_d : 1'b1;
        spi_mosi_d = (state_d == S_SHIFT) ? cmd_cur[bit_d] : 1'b1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            ph_q       <= 1'b0;
            bit_q      <= 3'd0;
            byte_q     <= 4'd0;
            sr_q       <= 8'h00;
            rx_q       <= '0;
            buttons_q  <= 16'h0000;
            mode_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            spi_cs_q   <= 1'b1;
            spi_clk_q  <= 1'b1;
            spi_mosi_q <= 1'b1;
`ifdef PS2_ANALOG_EN
            cfg_q      <= 2'd1;
            rx_stick_q <= 8'h80;
            ry_stick_q <= 8'h80;
            lx_stick_q <= 8'h80;
            ly_stick_q <= 8'h80;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            buttons_q  <= buttons_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            spi_cs_q   <= spi_cs_d;
            spi_clk_q  <= spi_clk_d;
            spi_mosi_q <= spi_mosi_d;
`ifdef PS2_ANALOG_EN
            cfg_q      <= cfg_d;
            rx_stick_q <= rx_stick_d;
            ry_stick_q <= ry_stick_d;
            lx_stick_q <= lx_stick_d;
            ly_stick_q <= ly_stick_d;
`endif
        end
    end

    assign spi_cs    = spi_cs_q;
    assign spi_clk   = spi_clk_q;
    assign spi_mosi  = spi_mosi_q;
    assign buttons   = buttons_q;
    assign mode_id   = mode_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef PS2_ANALOG_EN
    assign stick_rx  = rx_stick_q;
    assign stick_ry  = ry_stick_q;
    assign stick_lx  = lx_stick_q;
    assign stick_ly  = ly_stick_q;
`endif

endmodule

// File: tb/tb_ps2_pad_poller.sv
// tb_ps2_pad_poller: bench for ps2_pad_poller with a behavioural pad and a
// frame-level reference model. Builds with or without PS2_ANALOG_EN.
module tb_ps2_pad_poller;

    localparam int CLK_DIV = 2;
    localparam int GAP     = 4;
    localparam int POLL    = 200;
`ifdef PS2_ANALOG_EN
    localparam int NB = 9;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME_LOW = GAP * (NB + 1) + 16 * CLK_DIV * NB;

    localparam logic [71:0] CMD_POLL = 72'h01_42_00_00_00_00_00_00_00;
    localparam logic [71:0] CMD_CFG1 = 72'h01_43_00_01_00_00_00_00_00;
    localparam logic [71:0] CMD_CFG2 = 72'h01_44_00_01_03_00_00_00_00;
    localparam logic [71:0] CMD_CFG3 = 72'h01_43_00_00_5A_5A_5A_5A_5A;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        spi_clk, spi_cs, spi_mosi, spi_miso;
    logic [15:0] buttons;
    logic [7:0]  mode_id;
    logic        valid, err;
    logic [2:0]  dbg_state;
`ifdef PS2_ANALOG_EN
    logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
`endif

    always #5 clk = ~clk;

    ps2_pad_poller #(
        .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .buttons(buttons),
`ifdef PS2_ANALOG_EN
        .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
`endif
        .mode_id(mode_id), .valid(valid), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- pad model ----------------
    logic [7:0] pad_resp [9];
    logic [7:0] cur_byte;
    logic [7:0] mosi_q [$];
    int         pcnt = 0;
    int         sck_falls = 0;

    initial spi_miso = 1'b1;
    always @(negedge spi_cs) begin
        pcnt = 0;
        sck_falls = 0;
        mosi_q.delete();
    end
    always @(posedge spi_cs) spi_miso = 1'b1;
    always @(negedge spi_clk) begin
        if (spi_cs === 1'b0) begin
            sck_falls++;
            if (pcnt / 8 < 9) spi_miso = pad_resp[pcnt / 8][pcnt % 8];
            else spi_miso = 1'b1;
        end
    end
    always @(posedge spi_clk) begin
        if (spi_cs === 1'b0) begin
            cur_byte[pcnt % 8] = spi_mosi;
            if (pcnt % 8 == 7) mosi_q.push_back(cur_byte);
            pcnt++;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          since_rise = 0;
    bit          skip_period = 1'b1;
    logic [15:0] exp_buttons;
    logic [7:0]  exp_mode;
    logic [31:0] exp_sticks;   // {rx, ry, lx, ly}
    int          exp_cfg;      // pending config frames: 0 none, else next config frame number

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        since_rise++;
    endtask

    task automatic model_reset();
        exp_buttons = 16'h0000;
        exp_mode    = 8'h00;
        exp_sticks  = 32'h80808080;
`ifdef PS2_ANALOG_EN
        exp_cfg = 1;
`else
        exp_cfg = 0;
`endif
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_buttons"}, buttons, exp_buttons);
        check({pfx, "_mode_id"}, mode_id, exp_mode);
`ifdef PS2_ANALOG_EN
        check({pfx, "_sticks"}, {stick_rx, stick_ry, stick_lx, stick_ly}, exp_sticks);
`endif
    endtask

    // Wait for a frame, observe it pin by pin, then compare with the model.
    task automatic run_frame(input logic [71:0] r, input bit drop_en);
        int n, low, pulses, run, first_fall, lo_min, lo_max, hi_min, kind;
        logic prev, v, e;
        logic [71:0] exp_cmd;
        logic [7:0] b [9];
        for (int i = 0; i < 9; i++) begin
            b[i] = r[71 - 8 * i -: 8];
            pad_resp[i] = b[i];
        end
        kind = exp_cfg;
        n = 0;
        while (spi_cs !== 1'b0 && n < 4 * POLL) begin
            tick();
            n++;
        end
        check("frame_start_cs", spi_cs, 1'b0);
        if (!skip_period) check("poll_period", since_rise, POLL + 2);
        skip_period = 1'b0;

        low = 1; pulses = 0; run = 1; prev = spi_clk; first_fall = 0;
        lo_min = 1000; lo_max = 0; hi_min = 1000;
        while (low < 4 * FRAME_LOW) begin
            tick();
            if (spi_cs !== 1'b0) break;
            low++;
            if (valid === 1'b1 || err === 1'b1) pulses++;
            if (spi_clk !== prev) begin
                if (prev === 1'b0) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end else if (run < hi_min) begin
                    hi_min = run;
                end
                if (first_fall == 0 && spi_clk === 1'b0) first_fall = low;
                prev = spi_clk;
                run = 1;
            end else begin
                run++;
            end
            if (drop_en && low == FRAME_LOW / 2) en = 1'b0;
        end
        since_rise = 0;

        // Frame-level expectation.
        exp_cmd = CMD_POLL;
        v = 1'b0;
        e = 1'b0;
        if (kind != 0) begin
            exp_cmd = (kind == 1) ? CMD_CFG1 : (kind == 2) ? CMD_CFG2 : CMD_CFG3;
            exp_cfg = (kind == 3) ? 0 : kind + 1;
        end else if (b[2] == 8'h5A) begin
            v = 1'b1;
            exp_mode = b[1];
            exp_buttons = ~{b[4], b[3]};
`ifdef PS2_ANALOG_EN
            exp_sticks = {b[5], b[6], b[7], b[8]};
            if (b[1] != 8'h73) exp_cfg = 1;
`endif
        end else begin
            e = 1'b1;
        end

        check("cs_low_cycles", low, FRAME_LOW);
        check("cs_to_first_fall", first_fall - 1, GAP);
        check("sck_low_min", lo_min, CLK_DIV);
        check("sck_low_max", lo_max, CLK_DIV);
        check("sck_high_min", hi_min, CLK_DIV);
        check("sck_falls", sck_falls, 8 * NB);
        check("strobe_in_frame", pulses, 0);
        check("valid", valid, v);
        check("err", err, e);
        check_outputs("frame");
        check("mosi_count", mosi_q.size(), NB);
        for (int i = 0; i < NB && i < mosi_q.size(); i++)
            check($sformatf("mosi_byte%0d", i), mosi_q[i], exp_cmd[71 - 8 * i -: 8]);
        tick();
        check("valid_one_cycle", valid, 1'b0);
        check("err_one_cycle", err, 1'b0);
        check("mosi_idle", spi_mosi, 1'b1);
    endtask

    function automatic logic [71:0] rand_resp();
        logic [71:0] r;
        r = {$urandom(), $urandom(), 8'($urandom())};
        if ($urandom_range(3, 0) != 0) r[63:56] = 8'h73;
        if ($urandom_range(3, 0) != 0) r[55:48] = 8'h5A;
        return r;
    endfunction

    task automatic drain_config();
        while (exp_cfg != 0) run_frame(rand_resp(), 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 9; i++) pad_resp[i] = 8'hFF;
        model_reset();
        repeat (5) tick();
        check("rst_cs", spi_cs, 1'b1);
        check("rst_clk", spi_clk, 1'b1);
        check("rst_mosi", spi_mosi, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        check_outputs("rst");

        rst = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            if (spi_cs === 1'b0) n++;
        end
        check("idle_without_en", n, 0);

        en = 1'b1;
        drain_config();
        run_frame(72'hFF_41_5A_FE_7F_00_00_00_00, 1'b0);
        check("tp_buttons", buttons, 16'h8001);
        check("tp_mode_id", mode_id, 8'h41);
        drain_config();

        run_frame(72'hFF_41_00_12_34_00_00_00_00, 1'b0);
        check("err_hold_buttons", buttons, 16'h8001);

        for (int k = 0; k < 6; k++) run_frame(rand_resp(), 1'b0);
        drain_config();

`ifdef PS2_ANALOG_EN
        run_frame(72'h00_73_5A_FF_FF_10_20_30_40, 1'b0);
        check("tp_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h10203040);
        check("tp_buttons_zero", buttons, 16'h0000);
`endif
        run_frame(72'h00_73_5A_0F_F0_11_22_33_44, 1'b0);
        check("pre_rst_buttons", buttons, 16'h0FF0);

        // Reset in the middle of byte 2.
        n = 0;
        while (spi_cs !== 1'b0 && n < 4 * POLL) begin
            tick();
            n++;
        end
        check("rst_frame_start", spi_cs, 1'b0);
        n = 0;
        while (pcnt < 19 && n < FRAME_LOW) begin
            tick();
            n++;
        end
        check("rst_point", pcnt, 19);
        rst = 1'b1;
        tick();
        model_reset();
        check("midrst_cs", spi_cs, 1'b1);
        check("midrst_clk", spi_clk, 1'b1);
        check("midrst_mosi", spi_mosi, 1'b1);
        check("midrst_valid", valid, 1'b0);
        check_outputs("midrst");
        rst = 1'b0;
        skip_period = 1'b1;
        drain_config();
        run_frame(72'h00_73_5A_7E_BD_01_02_03_04, 1'b0);

        // Drop en mid-frame: frame completes, then CS stays high.
        run_frame(72'h00_73_5A_55_AA_05_06_07_08, 1'b1);
        check("drop_en_buttons", buttons, 16'h55AA);
        n = 0;
        repeat (3 * POLL) begin
            tick();
            if (spi_cs === 1'b0 || valid === 1'b1) n++;
        end
        check("stopped_after_en_low", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
